lamp_pwm_driver: RTL and testbench

Output stage of the lighting path. Consumes the 2-bit luminosity code and the 2-bit color code produced by the light controller and drives three LED channels (warm, cool, blue) with PWM. Brightness and color changes fade gradually rather than jumping. Sits between light_control and the LED driver pins.

---
 rtl/lamp_pwm_driver_if.sv | 20 ++
 rtl/lamp_pwm_driver.sv | 141 ++++++++++++++
 tb/tb_lamp_pwm_driver.sv | 180 ++++++++++++++++++
 3 files changed

// File: rtl/lamp_pwm_driver_if.sv
// Control codes into the lamp PWM stage and the three LED channel outputs
// plus the fade-in-progress flag coming back.
interface lamp_pwm_driver_if;
    logic [1:0] luminosity;
    logic [1:0] color;
    logic       warm_pwm;
    logic       cool_pwm;
    logic       blue_pwm;
    logic       busy;

    modport master (
        output luminosity, color,
        input  warm_pwm, cool_pwm, blue_pwm, busy
    );

    modport slave (
        input  luminosity, color,
        output warm_pwm, cool_pwm, blue_pwm, busy
    );
endinterface

// File: rtl/lamp_pwm_driver.sv
// Three-channel LED PWM stage: maps luminosity/color codes to per-channel
// targets, fades channel levels toward them, and latches duty at period edges.
module lamp_pwm_driver #(
    parameter int unsigned PWM_BITS = 8,
    parameter int unsigned FADE_DIV = 64,
    parameter int unsigned STEP     = 1
) (
    input  logic               clk,
    input  logic               reset,
    lamp_pwm_driver_if.slave   bus
);

    localparam int unsigned TICK_W = (FADE_DIV > 1) ? $clog2(FADE_DIV) : 1;
    localparam logic [PWM_BITS-1:0] MAX       = {PWM_BITS{1'b1}};
    localparam logic [PWM_BITS-1:0] HALF      = PWM_BITS'(1 << (PWM_BITS - 1));
    localparam logic [PWM_BITS-1:0] QUARTER   = PWM_BITS'(1 << (PWM_BITS - 2));
    localparam logic [PWM_BITS-1:0] STEP_V    = PWM_BITS'(STEP);
    localparam logic [TICK_W-1:0]   TICK_LAST = TICK_W'(FADE_DIV - 1);

    // Channel index order inside every per-channel vector.
    localparam int WARM = 0;
    localparam int COOL = 1;
    localparam int BLUE = 2;

    typedef enum logic {
        IDLE,
        FADING
    } fade_state_t;

    fade_state_t                   state, state_d;
    logic [3:0]                    in_q;
    logic [TICK_W-1:0]             tick_cnt, tick_d;
    logic [2:0][PWM_BITS-1:0]      level, level_d;
    logic [2:0][PWM_BITS-1:0]      target;
    logic [2:0][PWM_BITS-1:0]      duty_q;
    logic [2:0]                    pwm_q;
    logic [PWM_BITS-1:0]           cnt;
    logic [PWM_BITS-1:0]           bright;
    logic                          all_match;

    // Moves one level toward its target by at most STEP, never past it.
    function automatic logic [PWM_BITS-1:0] approach(
        input logic [PWM_BITS-1:0] cur,
        input logic [PWM_BITS-1:0] tgt
    );
        logic [PWM_BITS-1:0] diff;
        if (tgt > cur) begin
            diff = tgt - cur;
            return cur + ((diff < STEP_V) ? diff : STEP_V);
        end else begin
            diff = cur - tgt;
            return cur - ((diff < STEP_V) ? diff : STEP_V);
        end
    endfunction

    // Targets come only from the captured codes, never straight from the pins.
    always_comb begin
        bright = '0;
        target = '0;
        unique case (in_q[3:2])
            2'b11:   bright = MAX;
            2'b10:   bright = HALF;
            2'b01:   bright = QUARTER;
            default: bright = '0;
        endcase
        unique case (in_q[1:0])
            2'b00: begin
                target[WARM] = bright;
                target[COOL] = bright;
            end
            2'b01:   target[COOL] = bright;
            2'b10:   target[BLUE] = bright;
            default: target[WARM] = bright;
        endcase
    end

    assign all_match = (level == target);

    // NOTE: every output of this block gets a default first, so no path
    // through the case leaves a signal unassigned and no latch is inferred.
    always_comb begin
        state_d = state;
        tick_d  = tick_cnt;
        level_d = level;
        unique case (state)
            IDLE: begin
                tick_d = '0;
                if (!all_match) state_d = FADING;
            end
            FADING: begin
                if (all_match) begin
                    state_d = IDLE;
                    tick_d  = '0;
                end else begin
                    tick_d = (tick_cnt == TICK_LAST) ? '0 : tick_cnt + 1'b1;
                    if (tick_cnt == TICK_LAST) begin
                        for (int ch = 0; ch < 3; ch++)
                            level_d[ch] = approach(level[ch], target[ch]);
                    end
                end
            end
            default: state_d = IDLE;
        endcase
    end

    // NOTE: sequential state uses non-blocking assignments so every register
    // samples the pre-edge values regardless of statement order.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state    <= IDLE;
            in_q     <= '0;
            tick_cnt <= '0;
            level    <= '0;
        end else begin
            state    <= state_d;
            in_q     <= {bus.luminosity, bus.color};
            tick_cnt <= tick_d;
            level    <= level_d;
        end
    end

    // Duty is latched only at the end of a period, so pulses are never cut short.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            cnt    <= '0;
            duty_q <= '0;
            pwm_q  <= '0;
        end else begin
            cnt <= (cnt == MAX - 1'b1) ? '0 : cnt + 1'b1;
            if (cnt == MAX - 1'b1) duty_q <= level;
            for (int ch = 0; ch < 3; ch++)
                pwm_q[ch] <= (cnt < duty_q[ch]);
        end
    end

    assign bus.warm_pwm = pwm_q[WARM];
    assign bus.cool_pwm = pwm_q[COOL];
    assign bus.blue_pwm = pwm_q[BLUE];
    assign bus.busy     = !all_match;

endmodule

// File: tb/tb_lamp_pwm_driver.sv
// Directed bench for lamp_pwm_driver with PWM_BITS=4 (MAX=15), FADE_DIV=2, STEP=4.
module tb_lamp_pwm_driver;

    logic clk = 1'b0;
    logic reset;
    int   passed = 0;
    int   failed = 0;
    int   total  = 0;
    int   hw, hc, hb;
    int   n;

    always #5 clk = ~clk;

    lamp_pwm_driver_if bus ();

    lamp_pwm_driver #(
        .PWM_BITS (4),
        .FADE_DIV (2),
        .STEP     (4)
    ) dut (
        .clk   (clk),
        .reset (reset),
        .bus   (bus)
    );

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        total++;
        assert (obs === exp) passed++;
        else begin
            failed++;
            $error("FAIL %s: observed %0d expected %0d", tag, obs, exp);
        end
    endtask

    function automatic logic [11:0] levels();
        return {dut.level[0], dut.level[1], dut.level[2]};
    endfunction

    // Waits for the next change of any level, then checks the new triple and
    // the number of clocks it took (gap 0 skips the timing check).
    task automatic wait_step(input logic [3:0] ew, input logic [3:0] ec,
                             input logic [3:0] eb, input int gap, input string tag);
        logic [11:0] prev;
        int k;
        prev = levels();
        k = 0;
        do begin
            @(negedge clk);
            k++;
        end while (levels() === prev && k < 40);
        check({tag, " warm level"}, 32'(dut.level[0]), 32'(ew));
        check({tag, " cool level"}, 32'(dut.level[1]), 32'(ec));
        check({tag, " blue level"}, 32'(dut.level[2]), 32'(eb));
        if (gap > 0) check({tag, " step gap"}, 32'(k), 32'(gap));
    endtask

    task automatic count_highs(output int w, output int c, output int b);
        w = 0; c = 0; b = 0;
        repeat (15) begin
            @(negedge clk);
            w += int'(bus.warm_pwm);
            c += int'(bus.cool_pwm);
            b += int'(bus.blue_pwm);
        end
    endtask

    task automatic check_outputs(input string tag, input logic w, input logic c,
                                 input logic b, input logic bz);
        check({tag, " warm_pwm"}, 32'(bus.warm_pwm), 32'(w));
        check({tag, " cool_pwm"}, 32'(bus.cool_pwm), 32'(c));
        check({tag, " blue_pwm"}, 32'(bus.blue_pwm), 32'(b));
        check({tag, " busy"},     32'(bus.busy),     32'(bz));
    endtask

    initial begin
        // 1: held in reset while the inputs move around
        reset = 1'b0;
        bus.luminosity = 2'b11;
        bus.color      = 2'b00;
        for (int i = 0; i < 4; i++) begin
            @(negedge clk);
            bus.luminosity = 2'(i);
            bus.color      = 2'(3 - i);
            @(negedge clk);
            check_outputs("in reset", 1'b0, 1'b0, 1'b0, 1'b0);
        end
        check("in reset levels", 32'(levels()), 32'd0);

        // 2: release with high/natural, fade up 4,8,12,15
        bus.luminosity = 2'b11;
        bus.color      = 2'b00;
        @(negedge clk);
        reset = 1'b1;
        @(negedge clk);
        check("t2 busy after capture", 32'(bus.busy), 32'd1);
        wait_step(4'd4,  4'd4,  4'd0, 3, "t2 step1");
        wait_step(4'd8,  4'd8,  4'd0, 2, "t2 step2");
        wait_step(4'd12, 4'd12, 4'd0, 2, "t2 step3");
        wait_step(4'd15, 4'd15, 4'd0, 2, "t2 step4");
        check("t2 busy settled", 32'(bus.busy), 32'd0);
        repeat (32) @(negedge clk);
        count_highs(hw, hc, hb);
        check("t2 warm highs", 32'(hw), 32'd15);
        check("t2 cool highs", 32'(hc), 32'd15);
        check("t2 blue highs", 32'(hb), 32'd0);

        // 3: drop to mid brightness, 11 then 8
        bus.luminosity = 2'b10;
        wait_step(4'd11, 4'd11, 4'd0, 4, "t3 step1");
        wait_step(4'd8,  4'd8,  4'd0, 2, "t3 step2");
        @(negedge clk);
        check("t3 busy settled", 32'(bus.busy), 32'd0);
        repeat (32) @(negedge clk);
        count_highs(hw, hc, hb);
        check("t3 warm highs", 32'(hw), 32'd8);
        check("t3 cool highs", 32'(hc), 32'd8);
        check("t3 blue highs", 32'(hb), 32'd0);

        // 4: retarget to blue while fading up at level 8
        reset = 1'b0;
        bus.luminosity = 2'b11;
        bus.color      = 2'b00;
        @(negedge clk);
        reset = 1'b1;
        wait_step(4'd4, 4'd4, 4'd0, 4, "t4 up1");
        wait_step(4'd8, 4'd8, 4'd0, 2, "t4 up2");
        bus.color = 2'b10;
        wait_step(4'd4, 4'd4, 4'd4,  2, "t4 re1");
        wait_step(4'd0, 4'd0, 4'd8,  2, "t4 re2");
        check("t4 busy mid", 32'(bus.busy), 32'd1);
        wait_step(4'd0, 4'd0, 4'd12, 2, "t4 re3");
        wait_step(4'd0, 4'd0, 4'd15, 2, "t4 re4");
        check("t4 busy settled", 32'(bus.busy), 32'd0);
        repeat (32) @(negedge clk);
        count_highs(hw, hc, hb);
        check("t4 warm highs", 32'(hw), 32'd0);
        check("t4 cool highs", 32'(hc), 32'd0);
        check("t4 blue highs", 32'(hb), 32'd15);

        // 5: reset lands mid-fade at cnt=7, then fade restarts from 0
        bus.color = 2'b00;
        wait_step(4'd4, 4'd4, 4'd11, 4, "t5 fade");
        n = 0;
        while (dut.cnt !== 4'd7 && n < 40) begin
            @(negedge clk);
            n++;
        end
        check("t5 reached cnt 7", 32'(dut.cnt), 32'd7);
        check("t5 blue_pwm before reset", 32'(bus.blue_pwm), 32'd1);
        reset = 1'b0;
        #1;
        check_outputs("t5 during reset", 1'b0, 1'b0, 1'b0, 1'b0);
        check("t5 levels cleared", 32'(levels()), 32'd0);
        @(negedge clk);
        reset = 1'b1;
        wait_step(4'd4,  4'd4,  4'd0, 4, "t5 restart1");
        wait_step(4'd8,  4'd8,  4'd0, 2, "t5 restart2");
        wait_step(4'd12, 4'd12, 4'd0, 2, "t5 restart3");
        wait_step(4'd15, 4'd15, 4'd0, 2, "t5 restart4");

        // 6: settled high, fade all the way off
        repeat (4) @(negedge clk);
        bus.luminosity = 2'b00;
        wait_step(4'd11, 4'd11, 4'd0, 4, "t6 down1");
        wait_step(4'd7,  4'd7,  4'd0, 2, "t6 down2");
        wait_step(4'd3,  4'd3,  4'd0, 2, "t6 down3");
        wait_step(4'd0,  4'd0,  4'd0, 2, "t6 down4");
        check("t6 busy settled", 32'(bus.busy), 32'd0);
        repeat (32) @(negedge clk);
        count_highs(hw, hc, hb);
        check("t6 warm highs", 32'(hw), 32'd0);
        check("t6 cool highs", 32'(hc), 32'd0);
        check("t6 blue highs", 32'(hb), 32'd0);
        check("t6 busy idle", 32'(bus.busy), 32'd0);

        $display("%0d/%0d checks passed", passed, total);
        $finish;
    end

endmodule
